// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: Gray-coded {A,B} phase and direction codes.
// Latency: n/a (package). Backpressure: n/a.
package quad_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Next phase when the encoder turns in the counting-up direction.
    function automatic phase_t next_up(input phase_t ph);
        case (ph)
            PH_00:   return PH_10;
            PH_10:   return PH_11;
            PH_11:   return PH_01;
            default: return PH_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a stability filter for one encoder phase.
// Latency: 2 + FILT clk edges from input change to dout. Backpressure: none.
module quad_filter #(
    parameter int FILT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [7:0] CNT_LAST = 8'(FILT - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dout  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // Any edge where the synchronized value agrees restarts the run.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: filtered A/B phases drive an up/down position counter.
// Latency: FILT+3 clk edges from input change to pos/step. Backpressure: none.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FILT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err
);

    logic       a_filt;
    logic       b_filt;
    phase_t     cur;
    phase_t     prev;
    logic [1:0] diff;
    logic       moved;
    logic       illegal;
    logic       up;

    quad_filter #(.FILT(FILT)) u_filt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (a_in),
        .dout  (a_filt)
    );

    quad_filter #(.FILT(FILT)) u_filt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (b_in),
        .dout  (b_filt)
    );

    assign cur = phase_t'({a_filt, b_filt});

    always_comb begin
        diff    = cur ^ prev;
        moved   = |diff;
        illegal = &diff;
        up      = (cur == next_up(prev));
    end

    // prev keeps tracking even while disabled so re-enabling never sees a stale phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= PH_00;
            pos  <= '0;
            step <= 1'b0;
            dir  <= DIR_DOWN;
            err  <= 1'b0;
        end else begin
            prev <= cur;
            step <= 1'b0;
            if (illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (clr) begin
                pos <= '0;
            end else if (en && moved && !illegal) begin
                step <= 1'b1;
                dir  <= up ? DIR_UP : DIR_DOWN;
                pos  <= up ? pos + WIDTH'(1) : pos - WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, position counter width in bits.
REQ-002 The block SHALL have parameter FILT, default 4, input stability filter length in clk cycles, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_in  input  1  encoder phase A; asynchronous to clk.
REQ-006 b_in  input  1  encoder phase B; asynchronous to clk.
REQ-007 en  input  1  count enable; 1 = count, 0 = hold pos.
REQ-008 clr  input  1  synchronous position clear.
REQ-009 err_clr  input  1  synchronous clear of err.
REQ-010 pos  output  WIDTH  signed-agnostic position count, modulo 2^WIDTH.
REQ-011 step  output  1  one-cycle pulse per accepted counted transition.
REQ-012 dir  output  1  direction of last counted step; 1 = up, 0 = down.
REQ-013 err  output  1  sticky illegal-transition flag.

Function
REQ-014 Each of a_in, b_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each synchronized input SHALL drive a filtered value that updates only after the synchronized value differs from it for FILT consecutive rising edges; any return to equality restarts the count.
REQ-016 Pulses shorter than FILT cycles at the synchronizer output SHALL NOT change the filtered value.
REQ-017 Filtered {A,B} sequence 00->10->11->01->00 SHALL be an up step; the reverse sequence SHALL be a down step.
REQ-018 A filtered change of both A and B on the same edge SHALL set err, SHALL NOT change pos, step or dir.
REQ-019 When en=1 and clr=0, an up step SHALL increment pos by 1; a down step SHALL decrement pos by 1; both wrap modulo 2^WIDTH (max+1 -> 0, 0-1 -> max).
REQ-020 step SHALL be high for exactly one cycle, on the same edge pos updates; dir SHALL update on that edge and hold otherwise.
REQ-021 Latency: pos/step SHALL update on the (FILT+3)th rising edge, counting the first edge that samples the changed input as edge 1.
REQ-022 When en=0, the decoder SHALL keep tracking the filtered phase state but SHALL NOT change pos, step or dir; re-enabling SHALL NOT produce a spurious step.
REQ-023 clr=1 SHALL set pos to 0 on the next edge, overriding any coincident step; step SHALL be 0 on that edge.
REQ-024 err SHALL remain 1 until err_clr=1; a coincident err set and err_clr SHALL leave err=1.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock edge, force pos=0, step=0, dir=0, err=0, all synchronizer flops, filtered values and previous phase to 00, and filter counters to 0.
REQ-026 Reset assertion mid-step SHALL discard any in-flight filter count; no step SHALL be emitted as a result of reset release.

Structure
REQ-027 Shared package quad_pkg SHALL hold the 2-bit phase typedef (Gray states 00,10,11,01) and direction constants DIR_UP=1, DIR_DOWN=0.
REQ-028 Synchronizer plus stability filter SHALL be one sub-module, quad_filter, instantiated once per phase.
REQ-029 Transition decode and position counter SHALL reside in quad_decoder.

Verification (WIDTH=8, FILT=4)
REQ-030 From reset, drive {A,B} 00->10->11->01->00, each held 10 cycles -> pos 0->1->2->3->4, four step pulses, dir=1, each on edge 7 after its input change.
REQ-031 From pos=0, one down transition 00->01 -> pos=255, step pulse, dir=0.
REQ-032 3-cycle high glitch on a_in with B static -> pos, step, dir, err unchanged.
REQ-033 {A,B} 00->11 on one edge -> err=1, pos unchanged, no step; err_clr=1 one cycle -> err=0; err set coincident with err_clr -> err=1.
REQ-034 en=0 during two up steps, then en=1 and one further up step -> pos advances by exactly 1, one step pulse total.
REQ-035 rst_n low mid-sequence with pos=5 -> pos, step, dir, err 0 before next clk edge; clr=1 coincident with an up step -> pos=0, step=0.
